// File: rtl/rx_link_pkg.sv
// Shared definitions for the 32-bit link receiver.
//   SYNC_DEFAULT : header sync pattern carried in word bits [31:16]
//   *_HI/*_LO    : header field slice positions (sync, sequence, length)
//   rx_state_t   : frame-parser states
//   fifo_word_t  : payload FIFO entry {last, data}
package rx_link_pkg;

  localparam logic [15:0] SYNC_DEFAULT = 16'hA5A5;

  localparam int SYNC_HI = 31;
  localparam int SYNC_LO = 16;
  localparam int SEQ_HI  = 15;
  localparam int SEQ_LO  = 8;
  localparam int LEN_HI  = 7;
  localparam int LEN_LO  = 0;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } rx_state_t;

  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } fifo_word_t;

endpackage

// File: rtl/rx_fifo.sv
// Synchronous show-ahead FIFO for payload words.
//   clk, rst : clock and synchronous active-high reset (clears pointers/count)
//   push     : write wdata this cycle (ignored when full)
//   pop      : consume the head entry this cycle (ignored when empty)
//   rdata    : head entry, valid whenever empty=0; reads zero when empty
//   count    : number of stored entries (0..DEPTH)
//   full     : count == DEPTH
//   empty    : count == 0
module rx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 33,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Show-ahead: the head entry is driven straight from storage. Forcing zero
  // when empty keeps the output clean during and after reset.
  assign rdata = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/rx_frame_receiver.sv
// Receiving end of the 32-bit transmitter link.
// Grants transfer permission, parses the captured word stream into frames
// (header / LEN payload words / XOR checksum), checks sequence numbers and
// checksums, and buffers payload words for a valid/ready consumer.
//   clk, rst  : clock, synchronous active-high reset
//   data_in   : word from the transmitter
//   trfr_prm  : registered transfer permit to the transmitter
//   out_data  : payload word at FIFO head
//   out_last  : head word is the last payload word of its frame
//   out_valid : FIFO non-empty
//   out_ready : downstream accepts the head word
//   frame_ok  : 1-cycle pulse, checksum matched
//   frame_err : 1-cycle pulse, checksum mismatch
//   seq_err   : 1-cycle pulse, header sequence differed from expected
//   rx_active : parser is inside a frame (not hunting)
module rx_frame_receiver
  import rx_link_pkg::*;
#(
  parameter int          DEPTH = 8,
  parameter logic [15:0] SYNC  = SYNC_DEFAULT,
  parameter int          DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] data_in,
  output logic          trfr_prm,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          frame_ok,
  output logic          frame_err,
  output logic          seq_err,
  output logic          rx_active
);

  localparam int AW = $clog2(DEPTH);

  // Control state
  rx_state_t     state, state_nxt;
  logic [7:0]    remaining, remaining_nxt;
  logic [7:0]    exp_seq, exp_seq_nxt;
  logic [DW-1:0] acc, acc_nxt;
  logic          vld_p1;
  logic          prm_nxt;
  logic          ok_nxt, err_nxt, seq_err_nxt;

  // FIFO interface
  logic          push_word;
  logic          fifo_last;
  logic [DW:0]   fifo_rdata;
  logic [AW:0]   fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_pop;
  logic [AW+1:0] demand;

  // Header fields of the word being captured
  logic [15:0]   hdr_sync;
  logic [7:0]    hdr_seq;
  logic [7:0]    hdr_len;

  assign hdr_sync = data_in[SYNC_HI:SYNC_LO];
  assign hdr_seq  = data_in[SEQ_HI:SEQ_LO];
  assign hdr_len  = data_in[LEN_HI:LEN_LO];

  // Permit: a word permitted now arrives two cycles later. Both the word
  // being captured this cycle (vld_p1) and the one already permitted but not
  // yet on the wire (trfr_prm) are in flight, so both are reserved. Header and
  // checksum words are counted as if they consumed a slot, and pops are not
  // credited, which keeps the estimate conservative.
  assign demand  = {1'b0, fifo_count} + (AW+2)'(vld_p1) + (AW+2)'(trfr_prm) + (AW+2)'(1);
  assign prm_nxt = (demand <= (AW+2)'(DEPTH));

  // Frame parser, advanced only on captured words
  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    exp_seq_nxt   = exp_seq;
    acc_nxt       = acc;
    push_word     = 1'b0;
    fifo_last     = 1'b0;
    ok_nxt        = 1'b0;
    err_nxt       = 1'b0;
    seq_err_nxt   = 1'b0;
    if (vld_p1) begin
      case (state)
        HUNT: begin
          // Zero-length headers are treated as noise and do not touch exp_seq.
          if (hdr_sync == SYNC && hdr_len != 8'd0) begin
            state_nxt     = PAYLOAD;
            remaining_nxt = hdr_len;
            acc_nxt       = data_in;
            seq_err_nxt   = (hdr_seq != exp_seq);
            exp_seq_nxt   = hdr_seq + 8'd1;
          end
        end
        PAYLOAD: begin
          push_word     = 1'b1;
          fifo_last     = (remaining == 8'd1);
          acc_nxt       = acc ^ data_in;
          remaining_nxt = remaining - 8'd1;
          if (remaining == 8'd1) begin
            state_nxt = CHECK;
          end
        end
        CHECK: begin
          ok_nxt    = (data_in == acc);
          err_nxt   = (data_in != acc);
          state_nxt = HUNT;
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  // Stage p0 -> p1: permit register, capture enable and parser state
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HUNT;
      remaining <= '0;
      exp_seq   <= '0;
      trfr_prm  <= 1'b0;
      vld_p1    <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      seq_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      exp_seq   <= exp_seq_nxt;
      trfr_prm  <= prm_nxt;
      vld_p1    <= trfr_prm;
      frame_ok  <= ok_nxt;
      frame_err <= err_nxt;
      seq_err   <= seq_err_nxt;
    end
  end

  // Running checksum is pure data; it is always reloaded by a header.
  always_ff @(posedge clk) begin
    acc <= acc_nxt;
  end

  assign rx_active = (state != HUNT);
  assign fifo_pop  = out_valid & out_ready;

  rx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DW + 1)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_word & ~fifo_full),
    .wdata ({fifo_last, data_in}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_valid = ~fifo_empty;
  assign out_data  = fifo_rdata[DW-1:0];
  assign out_last  = fifo_rdata[DW];

  // A payload capture into a full FIFO means the permit logic let a word
  // through it could not hold; the word is dropped.
  a_capture_fits : assert property (@(posedge clk) disable iff (rst) !(push_word && fifo_full));

endmodule

// File: tb/tb_rx_frame_receiver.sv
module tb_rx_frame_receiver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data_in = '0;
  logic        trfr_prm;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        frame_ok;
  logic        frame_err;
  logic        seq_err;
  logic        rx_active;

  always #5 clk = ~clk;

  rx_frame_receiver #(.DEPTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .trfr_prm  (trfr_prm),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .seq_err   (seq_err),
    .rx_active (rx_active)
  );

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] txq[$];
  logic [32:0] got[$];
  int          ok_cnt, err_cnt, seq_cnt, sent, max_cnt;
  bit          act_seen;
  bit          prm_s;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic clear_stats();
    ok_cnt   = 0;
    err_cnt  = 0;
    seq_cnt  = 0;
    max_cnt  = 0;
    act_seen = 1'b0;
    got.delete();
  endtask

  // One clock: observe at the falling edge, then act as the transmitter,
  // presenting the next word just after the edge that followed a permit.
  task automatic tick();
    @(negedge clk);
    if (out_valid && out_ready) got.push_back({out_last, out_data});
    ok_cnt  += int'(frame_ok);
    err_cnt += int'(frame_err);
    seq_cnt += int'(seq_err);
    if (rx_active) act_seen = 1'b1;
    if (int'(dut.u_fifo.count) > max_cnt) max_cnt = int'(dut.u_fifo.count);
    prm_s = trfr_prm;
    @(posedge clk);
    #1;
    if (prm_s) begin
      if (txq.size() > 0) begin
        data_in = txq.pop_front();
        sent++;
      end else begin
        data_in = '0;
      end
    end
  endtask

  task automatic run_tx(input string tag, input int drain);
    int guard = 0;
    while (txq.size() > 0 && guard < 400) begin
      tick();
      guard++;
    end
    check_eq({tag, "_tx_done"}, 64'(txq.size()), 64'd0);
    repeat (drain) tick();
  endtask

  task automatic check_got(input string tag, input int idx, input logic [32:0] exp);
    check_eq(tag, (idx < got.size()) ? 64'(got[idx]) : 64'hDEAD_BEEF_DEAD, 64'(exp));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    txq.delete();
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    clear_stats();
    sent = 0;
    repeat (3) tick();
    check_eq("rst_prm",       64'(trfr_prm),  64'd0);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_data",  64'(out_data),  64'd0);
    check_eq("rst_out_last",  64'(out_last),  64'd0);
    check_eq("rst_pulses",    64'({frame_ok, frame_err, seq_err}), 64'd0);
    check_eq("rst_active",    64'(rx_active), 64'd0);
    rst = 1'b0;
    tick();
    check_eq("prm_cycle1", 64'(prm_s), 64'd0);
    tick();
    check_eq("prm_cycle2", 64'(prm_s), 64'd1);

    // Test 1: good frame, seq 00
    clear_stats();
    txq.push_back(32'hA5A5_0003);
    txq.push_back(32'h1); txq.push_back(32'h2); txq.push_back(32'h3);
    txq.push_back(32'hA5A5_0003);
    run_tx("t1", 8);
    check_eq("t1_ok",  64'(ok_cnt),  64'd1);
    check_eq("t1_err", 64'(err_cnt), 64'd0);
    check_eq("t1_seq", 64'(seq_cnt), 64'd0);
    check_eq("t1_len", 64'(got.size()), 64'd3);
    check_got("t1_w0", 0, {1'b0, 32'h1});
    check_got("t1_w1", 1, {1'b0, 32'h2});
    check_got("t1_w2", 2, {1'b1, 32'h3});

    // Test 2: bad checksum, seq 01; payload still delivered
    clear_stats();
    txq.push_back(32'hA5A5_0103);
    txq.push_back(32'h1); txq.push_back(32'h2); txq.push_back(32'h3);
    txq.push_back(32'h0000_0000);
    run_tx("t2", 8);
    check_eq("t2_ok",  64'(ok_cnt),  64'd0);
    check_eq("t2_err", 64'(err_cnt), 64'd1);
    check_eq("t2_seq", 64'(seq_cnt), 64'd0);
    check_got("t2_w0", 0, {1'b0, 32'h1});
    check_got("t2_w1", 1, {1'b0, 32'h2});
    check_got("t2_w2", 2, {1'b1, 32'h3});

    // Test 3: seq 00 then 02 after reset, then 03
    do_reset();
    clear_stats();
    txq.push_back(32'hA5A5_0001); txq.push_back(32'h7); txq.push_back(32'hA5A5_0006);
    txq.push_back(32'hA5A5_0201); txq.push_back(32'h9); txq.push_back(32'hA5A5_0208);
    run_tx("t3a", 6);
    check_eq("t3_seq_err", 64'(seq_cnt), 64'd1);
    check_eq("t3_ok2",     64'(ok_cnt),  64'd2);
    txq.push_back(32'hA5A5_0301); txq.push_back(32'h5); txq.push_back(32'hA5A5_0304);
    run_tx("t3b", 6);
    check_eq("t3_seq_next", 64'(seq_cnt), 64'd1);
    check_eq("t3_ok3",      64'(ok_cnt),  64'd3);
    check_got("t3_w2", 2, {1'b1, 32'h5});

    // Test 4: 20-word frame with downstream stalled
    clear_stats();
    out_ready = 1'b0;
    txq.push_back(32'hA5A5_0414);
    for (int i = 0; i < 20; i++) txq.push_back(32'h100 + 32'(i));
    txq.push_back(32'hA5A5_0414);
    repeat (40) tick();
    check_eq("t4_max_count", 64'(max_cnt), 64'd8);
    check_eq("t4_prm_low",   64'(prm_s),   64'd0);
    check_eq("t4_held",      64'(got.size()), 64'd0);
    out_ready = 1'b1;
    run_tx("t4", 14);
    check_eq("t4_len",  64'(got.size()), 64'd20);
    for (int i = 0; i < 20; i++)
      check_got($sformatf("t4_w%0d", i), i, {(i == 19), 32'h100 + 32'(i)});
    check_eq("t4_ok",   64'(ok_cnt),  64'd1);
    check_eq("t4_seq",  64'(seq_cnt), 64'd0);
    check_eq("t4_max2", 64'(max_cnt), 64'd8);

    // Test 5: garbage and LEN=0 header ignored
    clear_stats();
    txq.push_back(32'h1234_5678);
    txq.push_back(32'hA5A5_0100);
    run_tx("t5a", 4);
    check_eq("t5_idle",     64'(act_seen), 64'd0);
    check_eq("t5_no_words", 64'(got.size()), 64'd0);
    txq.push_back(32'hA5A5_0501); txq.push_back(32'hAB); txq.push_back(32'hA5A5_05AA);
    run_tx("t5b", 6);
    check_eq("t5_active", 64'(act_seen), 64'd1);
    check_eq("t5_ok",     64'(ok_cnt),   64'd1);
    check_eq("t5_seq",    64'(seq_cnt),  64'd0);
    check_got("t5_w0", 0, {1'b1, 32'hAB});

    // Test 6: reset after two of five payload words
    clear_stats();
    out_ready = 1'b0;
    sent = 0;
    txq.push_back(32'hA5A5_0605);
    for (int i = 0; i < 5; i++) txq.push_back(32'h11 + 32'(i));
    txq.push_back(32'hA5A5_0614);
    begin
      int guard = 0;
      while (sent < 3 && guard < 50) begin
        tick();
        guard++;
      end
    end
    check_eq("t6_sent", 64'(sent), 64'd3);
    tick();
    check_eq("t6_partial_buffered", 64'(out_valid), 64'd1);
    do_reset();
    check_eq("t6_fifo_empty", 64'(out_valid), 64'd0);
    check_eq("t6_inactive",   64'(rx_active), 64'd0);
    tick();
    check_eq("t6_prm_c1", 64'(prm_s), 64'd0);
    tick();
    check_eq("t6_prm_c2", 64'(prm_s), 64'd1);
    check_eq("t6_no_pulse", 64'(ok_cnt + err_cnt + seq_cnt), 64'd0);
    out_ready = 1'b1;
    txq.push_back(32'hA5A5_0002); txq.push_back(32'h21); txq.push_back(32'h22);
    txq.push_back(32'hA5A5_0001);
    run_tx("t6", 8);
    check_eq("t6_ok",  64'(ok_cnt),  64'd1);
    check_eq("t6_err", 64'(err_cnt), 64'd0);
    check_eq("t6_seq", 64'(seq_cnt), 64'd0);
    check_eq("t6_len", 64'(got.size()), 64'd2);
    check_got("t6_w0", 0, {1'b0, 32'h21});
    check_got("t6_w1", 1, {1'b1, 32'h22});

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
